// File: rtl/ingress_rr_arbiter.sv
// Packet-atomic round-robin arbiter merging NUM_PORTS word streams into one parser port.
// Optional per-port completed-packet counters are built when ARB_STATS_EN is defined.
module ingress_rr_arbiter #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS*32-1:0]       dataIn,
  input  logic [NUM_PORTS-1:0]          dataIn_val,
  input  logic [NUM_PORTS-1:0]          dataIn_last,
  output logic [NUM_PORTS-1:0]          dataIn_ready,
  output logic [31:0]                   dataOut,
  output logic                          dataOut_val,
  output logic                          dataOut_last,
  input  logic                          dataOut_ready,
  output logic [NUM_PORTS-1:0]          grant,
  input  logic [$clog2(NUM_PORTS)-1:0]  stat_sel,
  output logic [CNT_W-1:0]              stat_count
);

  localparam int unsigned IDX_W = $clog2(NUM_PORTS);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_FORWARD = 1'b1;

  logic [0:0]       state, state_nxt;
  logic [IDX_W-1:0] grant_idx, grant_idx_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] scan_idx;
  logic             pick_found;
  logic             xfer_last;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(NUM_PORTS - 1)) return '0;
    return idx + IDX_W'(1);
  endfunction

  // First requesting port at or after rr_ptr, wrapping around.
  always_comb begin
    pick_idx   = rr_ptr;
    pick_found = 1'b0;
    scan_idx   = rr_ptr;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!pick_found && dataIn_val[scan_idx]) begin
        pick_idx   = scan_idx;
        pick_found = 1'b1;
      end
      scan_idx = wrap_inc(scan_idx);
    end
  end

  // Combinational forwarding from the owning port; zeros whenever no valid word.
  always_comb begin
    dataOut      = '0;
    dataOut_val  = 1'b0;
    dataOut_last = 1'b0;
    dataIn_ready = '0;
    grant        = '0;
    if (state == S_FORWARD) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (grant_idx == IDX_W'(i)) begin
          grant[i]        = 1'b1;
          dataIn_ready[i] = dataOut_ready;
          if (dataIn_val[i]) begin
            dataOut_val  = 1'b1;
            dataOut_last = dataIn_last[i];
            dataOut      = dataIn[32*i +: 32];
          end
        end
      end
    end
  end

  assign xfer_last = dataOut_val & dataOut_ready & dataOut_last;

  always_comb begin
    state_nxt     = state;
    grant_idx_nxt = grant_idx;
    rr_ptr_nxt    = rr_ptr;
    case (state)
      S_IDLE: begin
        if (|dataIn_val) begin
          grant_idx_nxt = pick_idx;
          state_nxt     = S_FORWARD;
        end
      end
      S_FORWARD: begin
        if (xfer_last) begin
          rr_ptr_nxt = wrap_inc(grant_idx);
          state_nxt  = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      grant_idx <= '0;
      rr_ptr    <= '0;
    end else begin
      state     <= state_nxt;
      grant_idx <= grant_idx_nxt;
      rr_ptr    <= rr_ptr_nxt;
    end
  end

`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] pkt_cnt [NUM_PORTS];

  // Saturating completed-packet counters, bumped on each last-word transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PORTS; i++) pkt_cnt[i] <= '0;
    end else if (xfer_last && (pkt_cnt[grant_idx] != '1)) begin
      pkt_cnt[grant_idx] <= pkt_cnt[grant_idx] + CNT_W'(1);
    end
  end

  always_comb begin
    stat_count = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (stat_sel == IDX_W'(i)) stat_count = pkt_cnt[i];
    end
  end
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_count      = '0;
`endif

endmodule

// File: tb/tb_ingress_rr_arbiter.sv
// Randomized and directed bench for ingress_rr_arbiter against a packet-level reference model.
module tb_ingress_rr_arbiter;
  localparam int NP = 4;
  localparam int CW = 2;
  localparam int QD = 1024;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP*32-1:0]  dataIn;
  logic [NP-1:0]     dataIn_val, dataIn_last, dataIn_ready, grant;
  logic [31:0]       dataOut;
  logic              dataOut_val, dataOut_last, dataOut_ready;
  logic [1:0]        stat_sel;
  logic [CW-1:0]     stat_count;

  always #5 clk = ~clk;

  ingress_rr_arbiter #(.NUM_PORTS(NP), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .dataIn(dataIn), .dataIn_val(dataIn_val), .dataIn_last(dataIn_last),
    .dataIn_ready(dataIn_ready),
    .dataOut(dataOut), .dataOut_val(dataOut_val), .dataOut_last(dataOut_last),
    .dataOut_ready(dataOut_ready),
    .grant(grant), .stat_sel(stat_sel), .stat_count(stat_count)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  // Source word stores: bit 32 = last, [31:24] = port, [23:0] = running sequence.
  logic [32:0] mem [NP][QD];
  int head [NP];
  int tail [NP];
  int seq  [NP];

  // Reference model: owner (-1 idle), round-robin pointer, packet counts.
  int owner;
  int ptr;
  int cnt [NP];
  bit m_xfer, m_last;

  int vprob = 100, rprob = 100;
  logic [NP-1:0] stall_mask = '0;
  bit force_nready = 1'b0;
  bit fix_sel = 1'b0;

  logic [NP-1:0] s_grant, s_ready;
  logic          s_val, s_last;
  logic [31:0]   s_data;
  logic [CW-1:0] s_stat;

  int fair [16] = '{0, 1, 1, 0, 2, 2, 0, 4, 4, 0, 8, 8, 0, 1, 1, 0};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
  endtask

  task automatic push_pkt(input int p, input int len);
    for (int k = 0; k < len; k++) begin
      mem[p][tail[p] % QD] = {(k == len - 1), 8'(p), 24'(seq[p])};
      seq[p]++;
      tail[p]++;
    end
  endtask

  task automatic model_reset();
    owner = -1;
    ptr = 0;
    for (int p = 0; p < NP; p++) cnt[p] = 0;
  endtask

  function automatic bit busy();
    busy = (owner >= 0);
    for (int p = 0; p < NP; p++) if (head[p] != tail[p]) busy = 1'b1;
  endfunction

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      if (head[p] != tail[p] && !stall_mask[p] && ($urandom % 100) < vprob) begin
        dataIn_val[p]        = 1'b1;
        dataIn[32*p +: 32]   = mem[p][head[p] % QD][31:0];
        dataIn_last[p]       = mem[p][head[p] % QD][32];
      end else begin
        dataIn_val[p]        = 1'b0;
        dataIn[32*p +: 32]   = $urandom;
        dataIn_last[p]       = 1'($urandom % 2);
      end
    end
    dataOut_ready = !force_nready && (($urandom % 100) < rprob);
    stat_sel = fix_sel ? 2'd0 : 2'($urandom % NP);
  endtask

  // Expected outputs follow directly from who owns the output and what that port presents.
  task automatic compare();
    logic [NP-1:0] eg, er;
    logic ev, el;
    logic [31:0] ed;
    logic [CW-1:0] es;
    s_grant = grant; s_ready = dataIn_ready; s_val = dataOut_val;
    s_last = dataOut_last; s_data = dataOut; s_stat = stat_count;
    eg = '0; er = '0; ev = 1'b0; el = 1'b0; ed = '0;
    if (owner >= 0) begin
      eg[owner] = 1'b1;
      er[owner] = dataOut_ready;
      ev = dataIn_val[owner];
      if (ev) begin
        ed = dataIn[32*owner +: 32];
        el = dataIn_last[owner];
      end
    end
`ifdef ARB_STATS_EN
    es = CW'(cnt[stat_sel]);
`else
    es = '0;
`endif
    chk("grant", s_grant, eg);
    chk("in_ready", s_ready, er);
    chk("out_val", s_val, ev);
    chk("out_data", s_data, ed);
    chk("out_last", s_last, el);
    chk("stat_count", s_stat, es);
    m_xfer = ev && dataOut_ready;
    m_last = el;
  endtask

  task automatic update();
    if (reset) begin
      model_reset();
    end else if (owner < 0) begin
      for (int k = 0; k < NP; k++) begin
        if (owner < 0 && dataIn_val[(ptr + k) % NP]) owner = (ptr + k) % NP;
      end
    end else if (m_xfer) begin
      head[owner]++;
      if (m_last) begin
        if (cnt[owner] < (1 << CW) - 1) cnt[owner]++;
        ptr = (owner + 1) % NP;
        owner = -1;
      end
    end
  endtask

  task automatic step();
    drive();
    #4;
    compare();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic drain(input string nm, input int bound);
    int n = 0;
    while (busy() && n < bound) begin
      step();
      n++;
    end
    chk(nm, 64'(busy()), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    dataIn = '0; dataIn_val = '0; dataIn_last = '0; dataOut_ready = 1'b0; stat_sel = '0;
    for (int p = 0; p < NP; p++) begin head[p] = 0; tail[p] = 0; seq[p] = 0; end
    model_reset();
    m_xfer = 1'b0; m_last = 1'b0;
    #3;
    chk("rst_grant", grant, 0);
    chk("rst_ready", dataIn_ready, 0);
    chk("rst_val", dataOut_val, 0);
    chk("rst_data", dataOut, 0);
    chk("rst_last", dataOut_last, 0);
    chk("rst_stat", stat_count, 0);
    @(posedge clk); #1;
    step();
    reset = 1'b0;

    // All ports request 2-word packets: order 0,1,2,3,0 with one idle cycle between.
    push_pkt(0, 2); push_pkt(0, 2); push_pkt(1, 2); push_pkt(2, 2); push_pkt(3, 2);
    for (int c = 0; c < 16; c++) begin
      step();
      chk("fair_grant", s_grant, 64'(fair[c]));
    end
    drain("fair_drain", 50);

    // Single 3-word packet on port 2.
    push_pkt(2, 3);
    step(); chk("p2_c0_grant", s_grant, 4'b0000);
    step(); chk("p2_c1_grant", s_grant, 4'b0100); chk("p2_w0", s_data, 32'h0200_0002);
    step(); chk("p2_w1", s_data, 32'h0200_0003); chk("p2_w1_last", s_last, 1'b0);
    step(); chk("p2_w2", s_data, 32'h0200_0004); chk("p2_w2_last", s_last, 1'b1);
    step(); chk("p2_c4_grant", s_grant, 4'b0000);

    // Owner stalls while another port requests: grant must hold.
    push_pkt(1, 3);
    step();
    push_pkt(3, 2);
    step(); chk("stall_pre_grant", s_grant, 4'b0010);
    stall_mask = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("stall_grant", s_grant, 4'b0010);
      chk("stall_val", s_val, 1'b0);
    end
    stall_mask = '0;
    step(); chk("stall_w1_grant", s_grant, 4'b0010);
    step(); chk("stall_w2_last", s_last, 1'b1);
    step(); chk("stall_idle", s_grant, 4'b0000);
    step(); chk("stall_next_grant", s_grant, 4'b1000);
    drain("stall_drain", 50);

    // Downstream backpressure mid-packet.
    push_pkt(0, 4);
    step(); step();
    force_nready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("bp_ready", s_ready, 4'b0000);
      chk("bp_data", s_data, 32'h0000_0005);
    end
    force_nready = 1'b0;
    drain("bp_drain", 50);

    // Reset during word 2 of a 4-word packet.
    push_pkt(3, 4);
    step(); step();
    drive();
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_val", dataOut_val, 0);
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_ready", dataIn_ready, 0);
    model_reset();
    for (int p = 0; p < NP; p++) head[p] = tail[p];
    @(posedge clk); #1;
    step();
    reset = 1'b0;
    push_pkt(3, 1); push_pkt(2, 1); push_pkt(0, 1);
    step();
    step(); chk("post_rst_grant", s_grant, 4'b0001);
    drain("rst_drain", 50);

    // Port 0 completes five more packets; counter saturates at 3 when built.
    fix_sel = 1'b1;
    for (int k = 0; k < 5; k++) push_pkt(0, 1);
    drain("stat_drain", 100);
    step();
`ifdef ARB_STATS_EN
    chk("stat_sat", s_stat, 2'd3);
`else
    chk("stat_off", s_stat, 2'd0);
`endif

    // Randomized traffic with random valid/ready gaps.
    fix_sel = 1'b0;
    vprob = 75; rprob = 70;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom % 6 == 0) begin
        int p;
        p = int'($urandom % NP);
        if (tail[p] - head[p] < QD - 8) push_pkt(p, 1 + int'($urandom % 4));
      end
      step();
    end
    vprob = 100; rprob = 100;
    drain("rand_drain", 4000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/ingress_rr_arbiter.md
INGRESS_RR_ARBITER -- requirements
Module: ingress_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of upstream packet sources (2..8).
REQ-002 SHALL have parameter CNT_W, default 16, width of the per-port packet counters.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 dataIn  input  NUM_PORTS*32  per-port word; port i occupies bits [32*i+31:32*i].
REQ-007 dataIn_val  input  NUM_PORTS  per-port word valid.
REQ-008 dataIn_last  input  NUM_PORTS  per-port last word of packet.
REQ-009 dataIn_ready  output  NUM_PORTS  per-port accept.
REQ-010 dataOut  output  32  word to the parser.
REQ-011 dataOut_val  output  1  word valid to the parser.
REQ-012 dataOut_last  output  1  last word to the parser.
REQ-013 dataOut_ready  input  1  parser accept.
REQ-014 grant  output  NUM_PORTS  one-hot owner of the output; all zero when idle.
REQ-015 stat_sel  input  clog2(NUM_PORTS)  port selector for stat_count.
REQ-016 stat_count  output  CNT_W  packets completed on the selected port.

Function
REQ-017 SHALL implement two states: IDLE and FORWARD.
REQ-018 IDLE: all dataIn_ready=0, dataOut_val=0, grant=0; no word transfers in IDLE.
REQ-019 IDLE with any dataIn_val set: register grantIdx = first requesting port at or after rrPtr, scanning upward modulo NUM_PORTS; go to FORWARD next cycle.
REQ-020 FORWARD: dataOut, dataOut_val and dataOut_last SHALL equal the granted port's dataIn, dataIn_val and dataIn_last; this path is combinational.
REQ-021 FORWARD: dataIn_ready[grantIdx]=dataOut_ready; all other dataIn_ready=0.
REQ-022 dataOut and dataOut_last SHALL be 0 whenever dataOut_val=0.
REQ-023 A word transfers only on a cycle with dataOut_val=1 and dataOut_ready=1.
REQ-024 A transfer with dataOut_last=1 SHALL:
  - set rrPtr to (grantIdx+1) mod NUM_PORTS;
  - return the block to IDLE on the next cycle.
REQ-025 Arbitration SHALL be packet-atomic: the grant is never changed mid-packet, whether the owner drops dataIn_val or other ports request. There is no timeout.
REQ-026 Latency: the first word of a granted packet SHALL be presentable 1 cycle after arbitration; there is exactly 1 idle cycle between back-to-back packets.
REQ-027 A single persistent requester SHALL be re-granted after each IDLE cycle.
REQ-028 Fairness: with all ports continuously requesting, the grant order SHALL be 0,1,...,NUM_PORTS-1,0,...

Reset
REQ-029 On reset (asynchronous assert), the block SHALL immediately enter:
  - state IDLE, rrPtr=0, grant=0;
  - dataIn_ready=0, dataOut_val=0, dataOut=0, dataOut_last=0;
  - all counters 0, stat_count=0.
REQ-030 Reset during FORWARD SHALL abandon the packet; downstream sees dataOut_val drop in the same cycle. Upstream resynchronisation is the sources' responsibility.
REQ-031 Reset deassertion SHALL be synchronised; the first arbitration occurs on the first rising edge with reset low.

Configuration
REQ-032 Macro ARB_STATS_EN defined: one CNT_W saturating counter per port SHALL increment on each last-word transfer from that port and hold at all-ones.
REQ-033 With ARB_STATS_EN defined: stat_count=counter[stat_sel]; an out-of-range stat_sel returns 0.
REQ-034 ARB_STATS_EN undefined: no counters SHALL be built, stat_count is tied to 0, and stat_sel is ignored.

Verification
REQ-035 Port 2 sends a 3-word packet (last on word 3), dataOut_ready=1 -> grant=4'b0100 from cycle 1; words appear on dataOut cycles 1-3; IDLE on cycle 4.
REQ-036 All 4 ports request 2-word packets continuously -> grant sequence 0,1,2,3,0 with one idle cycle between packets.
REQ-037 Port 1 owns the output and stalls dataIn_val for 5 cycles while port 3 requests -> grant remains 4'b0010; port 3 is granted only after port 1's last word.
REQ-038 dataOut_ready held 0 for 4 cycles mid-packet -> dataIn_ready[grantIdx]=0 and no word is lost or duplicated.
REQ-039 Reset asserted on word 2 of a 4-word packet -> dataOut_val=0 and grant=0 in the same cycle; after release, port 0 is granted first (rrPtr=0).
REQ-040 With ARB_STATS_EN and CNT_W=2, port 0 completes 5 packets -> stat_count with stat_sel=0 reads 3 (saturated); without the macro it reads 0.
